// File: rtl/rah_pkg.sv
// Shared definitions for the stream demultiplexer: header layout, parser states, sizing helper.
package rah_pkg;

  // Header: app id sits directly above the LEN_W-bit length field.
  localparam int unsigned ID_W    = 8;
  localparam int unsigned LEN_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rah_sync_fifo.sv
// Per-app synchronous queue with registered read port and registered level flags.
module rah_sync_fifo
  import rah_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned FIFO_DEPTH          = 64,
  parameter int unsigned ALMOST_EMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  full_c
);

  localparam int unsigned AW = clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         level;
  logic [PW-1:0]         level_nxt;
  logic                  do_wr;
  logic                  do_rd;

  // Extra pointer bit separates full from empty when the index bits match.
  assign level  = wr_ptr - rd_ptr;
  assign full_c = (level == PW'(FIFO_DEPTH));
  assign do_wr  = wr_en && !full_c;
  assign do_rd  = rd_en && (wr_ptr != rd_ptr);

  always_comb begin
    level_nxt = level + PW'(do_wr) - PW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      rd_valid     <= do_rd;
      empty        <= (level_nxt == '0);
      almost_empty <= (level_nxt <= PW'(ALMOST_EMPTY_THRESH));
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + PW'(1);
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/rah_stream_demux.sv
// Parses headered packets from an unthrottled stream and steers payload words into per-app queues.
module rah_stream_demux
  import rah_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned TOTAL_APPS          = 4,
  parameter int unsigned FIFO_DEPTH          = 64,
  parameter int unsigned ALMOST_EMPTY_THRESH = 4,
  parameter int unsigned LEN_W               = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            mipi_data,
  input  logic                             mipi_rx_valid,
  input  logic [TOTAL_APPS-1:0]            request_data,
  input  logic [TOTAL_APPS-1:0]            error_clear,
  output logic                             end_of_packet,
  output logic                             bad_app_id,
  output logic [TOTAL_APPS-1:0]            data_queue_empty,
  output logic [TOTAL_APPS-1:0]            data_queue_almost_empty,
  output logic [TOTAL_APPS*DATA_WIDTH-1:0] rd_data,
  output logic [TOTAL_APPS-1:0]            rd_valid,
  output logic [TOTAL_APPS-1:0]            error
);

  state_e            state;
  logic [LEN_W-1:0]  remaining;
  logic [ID_W-1:0]   sel_id;
  logic [ID_W-1:0]   hdr_id;
  logic [LEN_W-1:0]  hdr_len;
  logic              id_ok;
  logic [TOTAL_APPS-1:0] wr_en;
  logic [TOTAL_APPS-1:0] full_c;
  logic [TOTAL_APPS-1:0] ovf;

  assign hdr_id  = mipi_data[LEN_W +: ID_W];
  assign hdr_len = mipi_data[LEN_LSB +: LEN_W];
  assign id_ok   = (32'(hdr_id) < TOTAL_APPS);

  // Parser: a word is consumed only when valid, so gaps freeze state and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      sel_id        <= '0;
      end_of_packet <= 1'b0;
      bad_app_id    <= 1'b0;
    end else begin
      end_of_packet <= 1'b0;
      bad_app_id    <= 1'b0;
      if (mipi_rx_valid) begin
        case (state)
          ST_IDLE: begin
            sel_id     <= hdr_id;
            remaining  <= hdr_len;
            bad_app_id <= !id_ok;
            if (hdr_len == '0) end_of_packet <= 1'b1;
            else               state <= id_ok ? ST_PAYLOAD : ST_DISCARD;
          end
          ST_PAYLOAD, ST_DISCARD: begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state         <= ST_IDLE;
              end_of_packet <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Overflow is judged on pre-edge fullness, so a same-cycle pop cannot rescue the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      error <= '0;
    end else begin
      for (int n = 0; n < int'(TOTAL_APPS); n++) begin
        if (ovf[n])              error[n] <= 1'b1;
        else if (error_clear[n]) error[n] <= 1'b0;
      end
    end
  end

  for (genvar n = 0; n < int'(TOTAL_APPS); n++) begin : g_app
    assign wr_en[n] = mipi_rx_valid && (state == ST_PAYLOAD) && (sel_id == ID_W'(n));
    assign ovf[n]   = wr_en[n] && full_c[n];

    rah_sync_fifo #(
      .DATA_WIDTH          (DATA_WIDTH),
      .FIFO_DEPTH          (FIFO_DEPTH),
      .ALMOST_EMPTY_THRESH (ALMOST_EMPTY_THRESH)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en[n]),
      .wr_data      (mipi_data),
      .rd_en        (request_data[n]),
      .rd_data      (rd_data[n*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid     (rd_valid[n]),
      .empty        (data_queue_empty[n]),
      .almost_empty (data_queue_almost_empty[n]),
      .full_c       (full_c[n])
    );
  end

endmodule
